i2c_uart_bridge_core: RTL



---
 rtl/i2c_uart_bridge_core.sv | 135 +++++++++++++
 1 files changed

// File: rtl/i2c_uart_bridge_core.sv
// i2c_uart_bridge_core: oversampled write-only I2C slave feeding a FIFO that drains into a UART transmitter.
module i2c_uart_bridge_core #(
  parameter logic [6:0] I2C_ADDR     = 7'h42,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         CLKS_PER_BIT = 87,
  parameter bit         PARITY_EN    = 1'b0,
  parameter bit         PARITY_ODD   = 1'b0
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_scl,
  input  logic                          i_sda,
  output logic                          o_sda_oe,
  output logic                          o_tx,
  output logic                          o_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  input  logic                          i_clr_ovf
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_ADDR_ACK = 3'd2,
                         S_DATA = 3'd3, S_DATA_ACK = 3'd4, S_IGNORE = 3'd5;
  localparam logic [2:0] U_IDLE = 3'd0, U_START = 3'd1, U_DATA = 3'd2,
                         U_PARITY = 3'd3, U_STOP = 3'd4;

  logic [2:0] scl_sh, sda_sh;
  logic       scl_rise, scl_fall, start_c, stop_c, byte_end, take, push, pop, ovf_set, full, empty;
  logic [2:0] i2c_state, u_state, u_bit;
  logic [3:0] bit_cnt;
  logic [7:0] shreg, u_byte;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [CW-1:0] u_cnt;
  logic [7:0] mem [FIFO_DEPTH];

  // [1:0] is the two-flop synchroniser, [2] holds the previous synced value for edge detection
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      scl_sh <= '1;
      sda_sh <= '1;
    end else begin
      scl_sh <= {scl_sh[1:0], i_scl};
      sda_sh <= {sda_sh[1:0], i_sda};
    end

  assign scl_rise = scl_sh[1] & ~scl_sh[2];
  assign scl_fall = ~scl_sh[1] & scl_sh[2];
  assign start_c  = scl_sh[1] & sda_sh[2] & ~sda_sh[1];
  assign stop_c   = scl_sh[1] & ~sda_sh[2] & sda_sh[1];
  assign byte_end = scl_fall & (bit_cnt == 4'd8);
  assign take     = i2c_state == S_ADDR ? shreg == {I2C_ADDR, 1'b0} : ~full;
  assign push     = byte_end & (i2c_state == S_DATA) & ~full;
  assign ovf_set  = byte_end & (i2c_state == S_DATA) & full;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      i2c_state <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      o_sda_oe  <= 1'b0;
    end else if (stop_c) begin
      i2c_state <= S_IDLE;
      o_sda_oe  <= 1'b0;
    end else if (start_c) begin
      i2c_state <= S_ADDR;
      bit_cnt   <= '0;
      o_sda_oe  <= 1'b0;
    end else begin
      case (i2c_state)
        S_ADDR, S_DATA:
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg   <= {shreg[6:0], sda_sh[1]};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_end) begin
            // ACK drive starts on the same SCL fall that closes the byte
            i2c_state <= !take ? S_IGNORE : i2c_state == S_ADDR ? S_ADDR_ACK : S_DATA_ACK;
            o_sda_oe  <= take;
          end
        S_ADDR_ACK, S_DATA_ACK:
          if (scl_fall) begin
            i2c_state <= S_DATA;
            bit_cnt   <= '0;
            o_sda_oe  <= 1'b0;
          end
        default: ;
      endcase
    end

  assign o_fifo_level = wr_ptr - rd_ptr;
  assign full  = o_fifo_level == (AW+1)'(FIFO_DEPTH);
  assign empty = o_fifo_level == '0;
  assign pop   = (u_state == U_IDLE) & ~empty;

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      o_overflow <= ovf_set | (o_overflow & ~i_clr_ovf);
    end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      u_state <= U_IDLE;
      u_cnt   <= '0;
      u_bit   <= '0;
      u_byte  <= '0;
    end else if (u_state == U_IDLE) begin
      if (pop) begin
        u_byte  <= mem[rd_ptr[AW-1:0]];
        u_state <= U_START;
        u_cnt   <= '0;
      end
    end else if (u_cnt != CNT_MAX) begin
      u_cnt <= u_cnt + CW'(1);
    end else begin
      u_cnt   <= '0;
      u_bit   <= u_state == U_DATA ? u_bit + 3'd1 : 3'd0;
      u_state <= u_state == U_START ? U_DATA :
                 u_state == U_DATA ? (u_bit != 3'd7 ? U_DATA : PARITY_EN ? U_PARITY : U_STOP) :
                 u_state == U_PARITY ? U_STOP : U_IDLE;
    end

  assign o_tx = u_state == U_START ? 1'b0 :
                u_state == U_DATA ? u_byte[u_bit] :
                u_state == U_PARITY ? ^u_byte ^ PARITY_ODD : 1'b1;
  assign o_tx_busy = u_state != U_IDLE;
endmodule
